axi_legacy_write_sequencer: RTL and testbench

Controller that sequences AXI-style write address/data channel transfers onto a legacy active-low chip-select/strobe peripheral bus.
- Accepts one AW beat and one W beat in any order.
- Checks the address against a fixed window.
- Drives the CS_N/WR_N timing sequence, waiting on device ready with a timeout.
- Reports completion and errors as single-cycle pulses.
Sits between the system interconnect and a legacy-compatible peripheral, on clk_sys.

---
 rtl/axi_legacy_write_sequencer_pkg.sv | 28 ++
 rtl/axi_legacy_write_sequencer_if.sv | 16 +
 rtl/axi_legacy_write_sequencer_legacy_phase_timer.sv | 30 +++
 rtl/axi_legacy_write_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_axi_legacy_write_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/axi_legacy_write_sequencer_pkg.sv
// Shared types, default timing constants and the address-window helper for
// the AXI-to-legacy write sequencer.
package axi_legacy_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } seq_state_e;

   localparam int          DEF_SETUP_CYC   = 2;
   localparam int          DEF_STROBE_CYC  = 3;
   localparam int          DEF_HOLD_CYC    = 1;
   localparam int          DEF_TIMEOUT_CYC = 64;
   localparam logic [31:0] DEF_BASE_ADDR   = 32'h4000_0000;
   localparam int          DEF_WINDOW_BITS = 16;

   // True when the address bits above the window size match the base.
   function automatic logic window_hit(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned bits);
      return (addr >> bits) == (base >> bits);
   endfunction

endpackage

// File: rtl/axi_legacy_write_sequencer_if.sv
// AXI-style write address / write data channels.
// Handshake: a beat transfers on a rising clock edge where VALID and READY
// are both 1; the master holds VALID and the payload stable until then.
interface axi_legacy_write_sequencer_if;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] AWADDR;
   logic        WVALID;
   logic        WREADY;
   logic [31:0] WDATA;

   modport master (output AWVALID, AWADDR, WVALID, WDATA,
                   input  AWREADY, WREADY);
   modport slave  (input  AWVALID, AWADDR, WVALID, WDATA,
                   output AWREADY, WREADY);
endinterface

// File: rtl/axi_legacy_write_sequencer_legacy_phase_timer.sv
// Loadable down-counter used to time the SETUP, STROBE-minimum and HOLD
// phases. expired is high while the count sits at zero.
module legacy_phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);
   logic [W-1:0] cnt_q, cnt_d;

   // Load takes priority; otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == '0);
endmodule

// File: rtl/axi_legacy_write_sequencer.sv
// Sequences one captured AW/W pair onto a legacy CS_N/WR_N peripheral bus,
// with address-window check, ready wait with timeout, and error counting.
// Every output is driven from a flop whose next value is derived from the
// next state, so outputs line up exactly with the state they belong to.
module axi_legacy_write_sequencer
   import axi_legacy_seq_pkg::*;
#(
   parameter int          SETUP_CYC   = DEF_SETUP_CYC,
   parameter int          STROBE_CYC  = DEF_STROBE_CYC,
   parameter int          HOLD_CYC    = DEF_HOLD_CYC,
   parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          WINDOW_BITS = DEF_WINDOW_BITS
) (
   input  logic                       clk_sys,
   input  logic                       rst_n,
   axi_legacy_write_sequencer_if.slave axi,
   output logic                       CS_N,
   output logic                       WR_N,
   output logic                       RD_N,
   input  logic                       RDY_N,
   output logic [WINDOW_BITS-1:0]     LEG_ADDR,
   output logic [31:0]                LEG_DATA,
   output logic                       transaction_complete,
   output logic                       error_detected,
   output logic [7:0]                 err_count,
   output seq_state_e                 dbg_state
);
   localparam int MAXP = (SETUP_CYC > STROBE_CYC) ?
                         ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                         ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
   localparam int TW   = $clog2(MAXP) + 1;
   localparam int WW   = $clog2(TIMEOUT_CYC + 1);

   seq_state_e             state_q, state_d;
   logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [31:0]            awaddr_q, awaddr_d, wdata_q, wdata_d;
   logic                   err_q, err_d;
   logic [WW-1:0]          wait_q, wait_d;
   logic                   awready_q, awready_d, wready_q, wready_d;
   logic                   cs_n_q, cs_n_d, wr_n_q, wr_n_d;
   logic [WINDOW_BITS-1:0] leg_addr_q, leg_addr_d;
   logic [31:0]            leg_data_q, leg_data_d;
   logic                   tc_q, tc_d, ed_q, ed_d;
   logic [7:0]             err_count_q, err_count_d;
   logic                   tmr_load, tmr_expired;
   logic [TW-1:0]          tmr_val;
   logic                   aw_hs, w_hs;

   legacy_phase_timer #(.W(TW)) u_timer (
      .clk      (clk_sys),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   assign aw_hs = axi.AWVALID & awready_q;
   assign w_hs  = axi.WVALID  & wready_q;

   // Next-state, capture and registered-output computation.
   always_comb begin
      state_d     = state_q;
      aw_held_d   = aw_held_q;
      w_held_d    = w_held_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      wait_d      = wait_q;
      leg_addr_d  = leg_addr_q;
      leg_data_d  = leg_data_q;
      err_count_d = err_count_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      case (state_q)
         ST_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awaddr_d  = axi.AWADDR;
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = axi.WDATA;
            end
            if (aw_held_d && w_held_d) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            wait_d = '0;
            if (window_hit(awaddr_q, BASE_ADDR, WINDOW_BITS)) begin
               leg_addr_d = awaddr_q[WINDOW_BITS-1:0];
               leg_data_d = wdata_q;
               tmr_load   = 1'b1;
               tmr_val    = TW'(SETUP_CYC - 1);
               state_d    = ST_SETUP;
            end else begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_SETUP: begin
            if (tmr_expired) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(STROBE_CYC - 1);
               state_d  = ST_STROBE;
            end
         end
         ST_STROBE: begin
            // Ready is only looked at once the minimum strobe has elapsed.
            if (tmr_expired) begin
               if (!RDY_N) begin
                  tmr_load = 1'b1;
                  tmr_val  = TW'(HOLD_CYC - 1);
                  state_d  = ST_HOLD;
               end else if (wait_q == WW'(TIMEOUT_CYC)) begin
                  err_d    = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = TW'(HOLD_CYC - 1);
                  state_d  = ST_HOLD;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (tmr_expired) state_d = ST_DONE;
         end
         ST_DONE: begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            err_d     = 1'b0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      awready_d = (state_d == ST_IDLE) && !aw_held_d;
      wready_d  = (state_d == ST_IDLE) && !w_held_d;
      cs_n_d    = !((state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                    (state_d == ST_HOLD));
      wr_n_d    = (state_d != ST_STROBE);
      tc_d      = (state_d == ST_DONE);
      ed_d      = (state_d == ST_DONE) && err_d;
      if (ed_d && (err_count_q != 8'hFF))
         err_count_d = err_count_q + 8'd1;
   end

   // State, capture and output registers.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         aw_held_q   <= 1'b0;
         w_held_q    <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         wait_q      <= '0;
         awready_q   <= 1'b1;
         wready_q    <= 1'b1;
         cs_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         leg_addr_q  <= '0;
         leg_data_q  <= '0;
         tc_q        <= 1'b0;
         ed_q        <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         aw_held_q   <= aw_held_d;
         w_held_q    <= w_held_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         wait_q      <= wait_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         cs_n_q      <= cs_n_d;
         wr_n_q      <= wr_n_d;
         leg_addr_q  <= leg_addr_d;
         leg_data_q  <= leg_data_d;
         tc_q        <= tc_d;
         ed_q        <= ed_d;
         err_count_q <= err_count_d;
      end
   end

   assign axi.AWREADY          = awready_q;
   assign axi.WREADY           = wready_q;
   assign CS_N                 = cs_n_q;
   assign WR_N                 = wr_n_q;
   assign RD_N                 = 1'b1;
   assign LEG_ADDR             = leg_addr_q;
   assign LEG_DATA             = leg_data_q;
   assign transaction_complete = tc_q;
   assign error_detected       = ed_q;
   assign err_count            = err_count_q;
   assign dbg_state            = state_q;
endmodule

// File: tb/tb_axi_legacy_write_sequencer.sv
// Randomised and directed bench for axi_legacy_write_sequencer. A timeline
// model predicts, per transaction, which cycles see ready, chip select,
// strobe and completion, using only the documented phase lengths.
module tb_axi_legacy_write_sequencer;
   import axi_legacy_seq_pkg::*;

   localparam int          S_CYC  = 2;
   localparam int          ST_CYC = 3;
   localparam int          H_CYC  = 1;
   localparam int          TO_CYC = 8;
   localparam int          WB     = 16;
   localparam logic [31:0] BASE   = 32'h4000_0000;

   logic          clk_sys = 1'b0;
   logic          rst_n   = 1'b0;
   logic          CS_N, WR_N, RD_N, RDY_N;
   logic [WB-1:0] LEG_ADDR;
   logic [31:0]   LEG_DATA;
   logic          transaction_complete, error_detected;
   logic [7:0]    err_count;
   seq_state_e    dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int err_cnt_m = 0;
   logic [WB-1:0] last_addr_m = '0;
   logic [31:0]   last_data_m = '0;
   logic [WB+32:0] exp_q[$];

   axi_legacy_write_sequencer_if axi_if ();

   axi_legacy_write_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
      .clk_sys              (clk_sys),
      .rst_n                (rst_n),
      .axi                  (axi_if.slave),
      .CS_N                 (CS_N),
      .WR_N                 (WR_N),
      .RD_N                 (RD_N),
      .RDY_N                (RDY_N),
      .LEG_ADDR             (LEG_ADDR),
      .LEG_DATA             (LEG_DATA),
      .transaction_complete (transaction_complete),
      .error_detected       (error_detected),
      .err_count            (err_count),
      .dbg_state            (dbg_state)
   );

   // Clock.
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One transaction: AW at cycle a, W at cycle w (relative to the first
   // idle cycle). rdy_mode 0 = ready low, 1 = never ready, 2 = random.
   // With do_abort the reset is pulled mid-strobe and the task returns.
   task automatic run_txn(input int a, input int w, input logic [31:0] addr,
                          input logic [31:0] data, input int rdy_mode,
                          input bit do_abort);
      logic rdy[64];
      logic [31:0] base_v;
      bit hit, tmo, err;
      int d, s0, m, e, done_c;
      logic [WB+32:0] rec;
      base_v = BASE;
      hit = (addr[31:WB] == base_v[31:WB]);
      for (int k = 0; k < 64; k++)
         rdy[k] = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 :
                  ($urandom_range(0, 3) != 0);
      d = ((a > w) ? a : w) + 1;
      s0 = d + S_CYC + 1;
      m = s0 + ST_CYC - 1;
      e = m + TO_CYC;
      tmo = 1'b0;
      if (hit) begin
         tmo = 1'b1;
         for (int k = m; k <= m + TO_CYC; k++)
            if (!rdy[k] && tmo) begin
               e = k;
               tmo = 1'b0;
            end
         done_c = e + H_CYC + 1;
         last_addr_m = addr[WB-1:0];
         last_data_m = data;
      end else begin
         done_c = d + 1;
      end
      err = !hit || tmo;
      if (!do_abort) exp_q.push_back({err, last_addr_m, last_data_m});

      for (int c = 0; c <= done_c; c++) begin
         @(posedge clk_sys);
         #1;
         axi_if.AWVALID = (c == a);
         axi_if.AWADDR  = (c == a) ? addr : $urandom;
         axi_if.WVALID  = (c == w);
         axi_if.WDATA   = (c == w) ? data : $urandom;
         RDY_N          = rdy[c];
         @(negedge clk_sys);
         if (c == done_c && err && err_cnt_m < 255) err_cnt_m++;
         chk("awready", axi_if.AWREADY, c <= a);
         chk("wready", axi_if.WREADY, c <= w);
         chk("cs_n", CS_N, !(hit && c >= d + 1 && c <= e + H_CYC));
         chk("wr_n", WR_N, !(hit && c >= s0 && c <= e));
         chk("rd_n", RD_N, 1'b1);
         chk("tc", transaction_complete, c == done_c);
         chk("err_count", err_count, err_cnt_m);
         if (transaction_complete) begin
            if (exp_q.size() == 0) chk("tc_spurious", 1, 0);
            else begin
               rec = exp_q.pop_front();
               chk("err_det", error_detected, rec[WB+32]);
               chk("leg_addr", LEG_ADDR, rec[WB+31:32]);
               chk("leg_data", LEG_DATA, rec[31:0]);
            end
         end else begin
            chk("err_idle", error_detected, 1'b0);
         end
         if (do_abort && c == s0 + 1) begin
            #2 rst_n = 1'b0;
            #1;
            chk("abort_cs_n", CS_N, 1'b1);
            chk("abort_wr_n", WR_N, 1'b1);
            chk("abort_tc", transaction_complete, 1'b0);
            err_cnt_m = 0;
            last_addr_m = '0;
            last_data_m = '0;
            axi_if.AWVALID = 1'b0;
            axi_if.WVALID  = 1'b0;
            return;
         end
      end
      axi_if.AWVALID = 1'b0;
      axi_if.WVALID  = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_awready", axi_if.AWREADY, 1'b1);
      chk("rst_wready", axi_if.WREADY, 1'b1);
      chk("rst_cs_n", CS_N, 1'b1);
      chk("rst_wr_n", WR_N, 1'b1);
      chk("rst_rd_n", RD_N, 1'b1);
      chk("rst_leg_addr", LEG_ADDR, 16'h0);
      chk("rst_leg_data", LEG_DATA, 32'h0);
      chk("rst_tc", transaction_complete, 1'b0);
      chk("rst_err", error_detected, 1'b0);
      chk("rst_err_count", err_count, 8'h0);
   endtask

   initial begin
      logic [31:0] addr;
      axi_if.AWVALID = 1'b0;
      axi_if.AWADDR  = '0;
      axi_if.WVALID  = 1'b0;
      axi_if.WDATA   = '0;
      RDY_N          = 1'b1;
      repeat (3) @(negedge clk_sys);
      check_reset_outputs();
      rst_n = 1'b1;

      // Nominal write, W-before-AW, window miss, timeout.
      run_txn(0, 0, 32'h4000_0010, 32'hDEAD_BEEF, 0, 1'b0);
      run_txn(3, 0, 32'h4000_1234, 32'h0123_4567, 0, 1'b0);
      run_txn(0, 0, 32'h5000_0000, 32'hCAFE_F00D, 0, 1'b0);
      run_txn(0, 0, 32'h4000_FFFC, 32'h1111_2222, 1, 1'b0);
      run_txn(1, 2, 32'h4000_0000, 32'h3333_4444, 2, 1'b0);

      // Reset during STROBE, then a normal transfer.
      run_txn(0, 0, 32'h4000_0020, 32'hAAAA_5555, 1, 1'b1);
      repeat (2) @(negedge clk_sys);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk_sys);
      chk("post_rst_awready", axi_if.AWREADY, 1'b1);
      chk("post_rst_wready", axi_if.WREADY, 1'b1);
      run_txn(0, 1, 32'h4000_0040, 32'h5A5A_A5A5, 0, 1'b0);

      // Randomised transfers.
      for (int i = 0; i < 40; i++) begin
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr[31:WB] = BASE[31:WB];
         else if (addr[31:WB] == BASE[31:WB]) addr[31] = ~addr[31];
         run_txn($urandom_range(0, 3), $urandom_range(0, 3), addr, $urandom,
                 $urandom_range(0, 2), 1'b0);
      end

      // Error counter saturation.
      for (int i = 0; i < 256; i++)
         run_txn(0, 0, 32'h5000_0000 + i, $urandom, 0, 1'b0);
      @(negedge clk_sys);
      chk("err_count_sat", err_count, 8'd255);
      chk("sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
